universal_shift_8bit: RTL and testbench
=======================================

Name: universal_shift_8bit

Overview:
- Clocked 8-bit universal shift register with four modes selected by a 2-bit code: shift left, hold, shift right, parallel load.
- Generic datapath utility for serializer and deserializer front-ends, bit-stream alignment, and scratch storage.
- Serial data enters at either end; the bit leaving each end is exposed as a serial output.

Parameters:
- WIDTH, 8, register width in bits. Port widths below use WIDTH; all test values assume 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- en  input  1  clock enable; when 0 the register holds regardless of s
- s  input  2  mode select: 00 shift left, 01 hold, 10 shift right, 11 parallel load
- a  input  WIDTH  parallel load data
- sl_in  input  1  serial bit entering at LSB on shift left
- sr_in  input  1  serial bit entering at MSB on shift right
- p  output  WIDTH  register contents
- shl_out  output  1  equals p[WIDTH-1], the bit lost on the next shift left
- shr_out  output  1  equals p[0], the bit lost on the next shift right
- rot  input  1  present only with ROTATE_EN; see Optional Feature

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- All state updates occur on the rising edge of clk. p is a register; shl_out and shr_out are combinational from p.
- Reset: when rst_n=0 at a rising edge, p becomes 0 (so shl_out=0, shr_out=0).
  - Reset has priority over en and s.
  - Reset asserted mid-sequence discards the contents on that edge.
  - rst_n has no effect between edges.
- When rst_n=1 and en=0, p holds.
- When rst_n=1 and en=1, the next value of p is:
  - s=00: p <= {p[WIDTH-2:0], sl_in}. MSB is discarded.
  - s=01: p <= p.
  - s=10: p <= {sr_in, p[WIDTH-1:1]}. LSB is discarded.
  - s=11: p <= a.
- Latency: one cycle from the sampled inputs to the updated p. No handshake; every enabled edge performs the selected operation.
- Shifting operates on the current register contents. a is ignored in all modes except 11.
- No X-propagation special case: all 4 codes are legal, so no illegal-state recovery is needed.
- Repeated shifts in one direction with a constant serial input fill the register with that bit after WIDTH cycles.

Optional Feature:
- Macro ROTATE_EN.
- Defined:
  - Input rot is present.
  - With rot=1, s=00 rotates left: LSB receives the old p[WIDTH-1], and sl_in is ignored.
  - With rot=1, s=10 rotates right: MSB receives the old p[0], and sr_in is ignored.
  - With rot=0, behaviour is as specified above.
  - rot has no effect in modes 01 and 11.
- Not defined: port rot does not exist, and shifts always use sl_in/sr_in.

Test Plan:
- Reset: rst_n=0 for one edge with s=11, a=0xFF, en=1 -> p=0x00, shl_out=0, shr_out=0.
- Load, then shift, hold and shift again (sl_in=0, sr_in=0, en=1):
  - s=11, a=0xDA -> p=0xDA
  - s=00 -> p=0xB4
  - s=01 for 2 cycles -> p stays 0xB4
  - s=10 -> p=0x5A
- Serial fill (sl_in=1, sr_in=1):
  - Load a=0xF0 -> p=0xF0, shl_out=1, shr_out=0.
  - s=00 -> p=0xE1.
  - s=10 -> p=0xF0.
- Enable gating: p=0x5A, en=0, s=11, a=0x00 for 3 cycles -> p stays 0x5A. Then en=1 -> p=0x00.
- Walk-out: load 0x01, s=10 with sr_in=0 -> p=0x00 after 1 edge, shr_out=1 before that edge. Load 0x80, s=00 with sl_in=0 for 8 edges -> p=0x00.
- ROTATE_EN build, rot=1:
  - Load 0x81, s=00 -> p=0x03.
  - s=10 -> p=0x81.
  - s=10 again -> p=0xC0.

Source files
------------

// File: rtl/universal_shift_8bit_if.sv
// Bus bundle for universal_shift_8bit: mode/enable controls, serial and parallel data.
// ROTATE_EN adds the rot control signal.
interface universal_shift_8bit_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       s;
    logic [WIDTH-1:0] a;
    logic             sl_in;
    logic             sr_in;
`ifdef ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] p;
    logic             shl_out;
    logic             shr_out;

    modport master (
        output en,
        output s,
        output a,
        output sl_in,
        output sr_in,
`ifdef ROTATE_EN
        output rot,
`endif
        input  p,
        input  shl_out,
        input  shr_out
    );

    modport slave (
        input  en,
        input  s,
        input  a,
        input  sl_in,
        input  sr_in,
`ifdef ROTATE_EN
        input  rot,
`endif
        output p,
        output shl_out,
        output shr_out
    );
endinterface

// File: rtl/universal_shift_8bit.sv
// Universal shift register: shift left, hold, shift right, parallel load.
// Optional macro ROTATE_EN adds rotate-through on the two shift modes.
module universal_shift_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    universal_shift_8bit_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_SHL  = 2'b00,
        MODE_HOLD = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] p_d;
    logic             sl_bit;
    logic             sr_bit;
    mode_e            mode;

    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                    input logic             b);
        return {v[WIDTH-2:0], b};
    endfunction

    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                     input logic             b);
        return {b, v[WIDTH-1:1]};
    endfunction

    assign mode = mode_e'(bus.s);

    // Bits entering each end; in rotate mode they come from the opposite end.
    always_comb begin
        sl_bit = bus.sl_in;
        sr_bit = bus.sr_in;
`ifdef ROTATE_EN
        if (bus.rot) begin
            sl_bit = p_q[WIDTH-1];
            sr_bit = p_q[0];
        end
`endif
    end

    always_comb begin
        p_d = p_q;
        if (bus.en) begin
            case (mode)
                MODE_SHL:  p_d = shift_left(p_q, sl_bit);
                MODE_HOLD: p_d = p_q;
                MODE_SHR:  p_d = shift_right(p_q, sr_bit);
                MODE_LOAD: p_d = bus.a;
                default:   p_d = p_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign bus.p       = p_q;
    assign bus.shl_out = p_q[WIDTH-1];
    assign bus.shr_out = p_q[0];

endmodule

// File: tb/tb_universal_shift_8bit.sv
// Randomised and directed bench for universal_shift_8bit against an arithmetic model.
module tb_universal_shift_8bit;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    logic [7:0] exp_p;
    logic       rot_m;

    universal_shift_8bit_if #(.WIDTH(8)) bus();

    universal_shift_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register modelled as an integer: left shift is *2 mod 256, right shift is /2.
    function automatic logic [7:0] model(input logic [7:0] cur, input logic rn, input logic en,
                                         input logic [1:0] s, input logic [7:0] a,
                                         input logic sl, input logic sr, input logic rt);
        int v;
        v = int'(cur);
        if (!rn) return 8'h00;
        if (!en) return cur;
        case (s)
            2'd0: v = (v * 2 + (rt ? v / 128 : int'(sl))) % 256;
            2'd1: v = v;
            2'd2: v = v / 2 + 128 * (rt ? v % 2 : int'(sr));
            default: v = int'(a);
        endcase
        return v[7:0];
    endfunction

    task automatic step(input logic rn, input logic en, input logic [1:0] s, input logic [7:0] a,
                        input logic sl, input logic sr, input logic rt);
        rst_n     = rn;
        bus.en    = en;
        bus.s     = s;
        bus.a     = a;
        bus.sl_in = sl;
        bus.sr_in = sr;
        rot_m     = rt;
`ifdef ROTATE_EN
        bus.rot   = rt;
`endif
        @(posedge clk);
        #1;
        exp_p = model(exp_p, rn, en, s, a, sl, sr, rt);
    endtask

    task automatic test_reset();
        exp_p = 8'h5C;
        step(1'b0, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (bus.p !== 8'h00) begin
            n_fail++; $display("FAIL reset_p got %h want %h", bus.p, 8'h00);
        end
        n_run++;
        if (bus.shl_out !== 1'b0 || bus.shr_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_serial got %b%b want 00", bus.shl_out, bus.shr_out);
        end
        exp_p = 8'h00;
    endtask

    task automatic test_load_shift_hold();
        logic [7:0] want [5] = '{8'hDA, 8'hB4, 8'hB4, 8'hB4, 8'h5A};
        logic [1:0] mode [5] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, mode[i], 8'hDA, 1'b0, 1'b0, 1'b0);
            n_run++;
            if (bus.p !== want[i]) begin
                n_fail++; $display("FAIL load_shift_hold[%0d] got %h want %h", i, bus.p, want[i]);
            end
        end
    endtask

    task automatic test_serial_fill();
        step(1'b1, 1'b1, 2'b11, 8'hF0, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (bus.p !== 8'hF0 || bus.shl_out !== 1'b1 || bus.shr_out !== 1'b0) begin
            n_fail++; $display("FAIL fill_load got %h/%b%b want f0/10", bus.p, bus.shl_out, bus.shr_out);
        end
        step(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (bus.p !== 8'hE1) begin
            n_fail++; $display("FAIL fill_shl got %h want e1", bus.p);
        end
        step(1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (bus.p !== 8'hF0) begin
            n_fail++; $display("FAIL fill_shr got %h want f0", bus.p);
        end
        step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
        n_run++;
        if (bus.p !== 8'hFF) begin
            n_fail++; $display("FAIL fill_ones got %h want ff", bus.p);
        end
    endtask

    task automatic test_enable();
        step(1'b1, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
            n_run++;
            if (bus.p !== 8'h5A) begin
                n_fail++; $display("FAIL enable_hold[%0d] got %h want 5a", i, bus.p);
            end
        end
        step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (bus.p !== 8'h00) begin
            n_fail++; $display("FAIL enable_load got %h want 00", bus.p);
        end
    endtask

    task automatic test_walkout();
        step(1'b1, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (bus.shr_out !== 1'b1) begin
            n_fail++; $display("FAIL walk_shr_before got %b want 1", bus.shr_out);
        end
        step(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (bus.p !== 8'h00) begin
            n_fail++; $display("FAIL walk_right got %h want 00", bus.p);
        end
        step(1'b1, 1'b1, 2'b11, 8'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
            n_run++;
            if (bus.p !== 8'h00) begin
                n_fail++; $display("FAIL walk_left[%0d] got %h want 00", i, bus.p);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b1, 2'b11, 8'hA7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (bus.p !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset got %h want 00", bus.p);
        end
    endtask

`ifdef ROTATE_EN
    task automatic test_rotate();
        logic [7:0] want [4] = '{8'h81, 8'h03, 8'h81, 8'hC0};
        logic [1:0] mode [4] = '{2'b11, 2'b00, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, mode[i], 8'h81, 1'b0, 1'b0, 1'b1);
            n_run++;
            if (bus.p !== want[i]) begin
                n_fail++; $display("FAIL rotate[%0d] got %h want %h", i, bus.p, want[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic rt;
        for (int i = 0; i < 300; i++) begin
            rt = 1'b0;
`ifdef ROTATE_EN
            rt = 1'($urandom_range(0, 1));
`endif
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rt);
            n_run++;
            if (bus.p !== exp_p || bus.shl_out !== exp_p[7] || bus.shr_out !== exp_p[0]) begin
                n_fail++;
                $display("FAIL random[%0d] got %h/%b%b want %h/%b%b", i, bus.p, bus.shl_out,
                         bus.shr_out, exp_p, exp_p[7], exp_p[0]);
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rot_m  = 1'b0;
        bus.en = 1'b0; bus.s = 2'b01; bus.a = 8'h00; bus.sl_in = 1'b0; bus.sr_in = 1'b0;
`ifdef ROTATE_EN
        bus.rot = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_load_shift_hold();
        test_serial_fill();
        test_enable();
        test_walkout();
        test_mid_reset();
`ifdef ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
